usb_dev_rw_responder: RTL and testbench

- Device-side (thumb-drive end) responder for the two-phase host read/write scheme, driven by the device protocol layer after token/data/CRC decode.
- Address phase: OUT to endpoint 4 carries a 16-bit memory address.
- Data phase: IN to endpoint 8 returns the 64-bit word at that address; OUT to endpoint 8 writes the 64-bit payload there.
- Generates USB handshakes (ACK/NAK/STALL) and drives a simple request/ack memory port.

---
 rtl/usb_dev_pkg.sv | 23 ++
 rtl/usb_dev_rw_responder_if.sv | 37 +++
 rtl/usb_dev_timer.sv | 31 +++
 rtl/usb_dev_rw_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_usb_dev_rw_responder.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/usb_dev_pkg.sv
// Shared types and default constants for the USB device read/write responder.
package usb_dev_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        MWR  = 3'd2,
        MRD  = 3'd3,
        TXD  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        HS_ACK   = 2'd0,
        HS_NAK   = 2'd1,
        HS_STALL = 2'd2
    } hs_code_t;

    localparam logic [6:0]  DEV_ADDR    = 7'd5;
    localparam logic [3:0]  ADDR_ENDP   = 4'd4;
    localparam logic [3:0]  DATA_ENDP   = 4'd8;
    localparam logic [15:0] TIMEOUT_DEF = 16'd4096;

endpackage

// File: rtl/usb_dev_rw_responder_if.sv
// Request/handshake/IN-data/memory bundle between the protocol layer, the responder and memory.
// valid/ready rule: req_valid, hs_valid, mem_ack and tx_ack are one-cycle pulses; mem_req is held until mem_ack; tx_valid is a level held until tx_ack.
interface usb_dev_rw_responder_if;
    logic        req_valid;
    logic        req_in;
    logic [6:0]  req_addr;
    logic [3:0]  req_endp;
    logic [63:0] req_data;
    logic        req_crc_ok;
    logic        abort;
    logic        hs_valid;
    logic [1:0]  hs_code;
    logic        tx_valid;
    logic [63:0] tx_data;
    logic        tx_ack;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic        timeout;

    modport slave (
        input  req_valid, req_in, req_addr, req_endp, req_data, req_crc_ok, abort,
               tx_ack, mem_rdata, mem_ack,
        output hs_valid, hs_code, tx_valid, tx_data, mem_req, mem_we, mem_addr,
               mem_wdata, timeout
    );

    modport master (
        output req_valid, req_in, req_addr, req_endp, req_data, req_crc_ok, abort,
               tx_ack, mem_rdata, mem_ack,
        input  hs_valid, hs_code, tx_valid, tx_data, mem_req, mem_we, mem_addr,
               mem_wdata, timeout
    );
endinterface

// File: rtl/usb_dev_timer.sv
// 16-bit idle counter with synchronous clear, count enable and a terminal-count flag.
module usb_dev_timer (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] tc_val,
    output logic        tc
);
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 16'd0;
        end else if (en) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // tc looks only at the registered count so the FSM can use it without a loop through clr.
    assign tc = en && (count_q == tc_val);
endmodule

// File: rtl/usb_dev_rw_responder.sv
// Device-side two-phase read/write responder: endpoint ADDR_ENDP sets the address, DATA_ENDP moves 64-bit words.
// Optional transfer statistics outputs are built when USB_DEV_RW_STATS_EN is defined.
module usb_dev_rw_responder #(
    parameter logic [6:0]  DEV_ADDR  = usb_dev_pkg::DEV_ADDR,
    parameter logic [3:0]  ADDR_ENDP = usb_dev_pkg::ADDR_ENDP,
    parameter logic [3:0]  DATA_ENDP = usb_dev_pkg::DATA_ENDP,
    parameter logic [15:0] TIMEOUT   = usb_dev_pkg::TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_L,
    usb_dev_rw_responder_if.slave bus,
    output usb_dev_pkg::state_t  dbg_state
`ifdef USB_DEV_RW_STATS_EN
    ,
    output logic [15:0]          wr_count,
    output logic [15:0]          rd_count,
    output logic [7:0]           crc_err_count
`endif
);
    import usb_dev_pkg::state_t;
    import usb_dev_pkg::hs_code_t;
    import usb_dev_pkg::IDLE;
    import usb_dev_pkg::ADDR;
    import usb_dev_pkg::MWR;
    import usb_dev_pkg::MRD;
    import usb_dev_pkg::TXD;
    import usb_dev_pkg::HS_ACK;
    import usb_dev_pkg::HS_NAK;
    import usb_dev_pkg::HS_STALL;

    state_t      state_q, state_d;
    hs_code_t    hs_code_q, hs_code_d;
    logic        hs_valid_q, hs_valid_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d, tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d, timeout_q, timeout_d;
    logic        abort_pend_q, abort_pend_d;
    logic        hit, is_addr, is_data, tmr_tc, tmr_clr, tmr_en;
    logic        crc_nak, wr_done, rd_done;

    assign tmr_en  = (state_q == ADDR) || (state_q == TXD);
    assign tmr_clr = (state_d != state_q) || hit;

    usb_dev_timer u_timer (
        .clk    (clk),
        .rst_L  (rst_L),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .tc_val (TIMEOUT - 16'd1),
        .tc     (tmr_tc)
    );

    always_comb begin
        hit          = bus.req_valid && (bus.req_addr == DEV_ADDR);
        is_addr      = (bus.req_endp == ADDR_ENDP);
        is_data      = (bus.req_endp == DATA_ENDP);
        state_d      = state_q;
        hs_valid_d   = 1'b0;
        hs_code_d    = hs_code_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        timeout_d    = 1'b0;
        abort_pend_d = abort_pend_q;
        crc_nak      = 1'b0;
        wr_done      = 1'b0;
        rd_done      = 1'b0;
        if ((state_q == MWR) || (state_q == MRD)) begin
            // Memory accesses always run to completion; an abort only silences the ending.
            if (bus.abort) abort_pend_d = 1'b1;
            if (bus.mem_ack) begin
                mem_req_d    = 1'b0;
                abort_pend_d = 1'b0;
                state_d      = IDLE;
                if (!(abort_pend_q || bus.abort)) begin
                    if (state_q == MWR) begin
                        hs_valid_d = 1'b1;
                        hs_code_d  = HS_ACK;
                        wr_done    = 1'b1;
                    end else begin
                        tx_data_d  = bus.mem_rdata;
                        tx_valid_d = 1'b1;
                        state_d    = TXD;
                    end
                end
            end else if (hit && !bus.abort) begin
                hs_valid_d = 1'b1;
                hs_code_d  = HS_NAK;
            end
        end else if (bus.abort) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
        end else if (hit && !(is_addr || is_data)) begin
            hs_valid_d = 1'b1;
            hs_code_d  = HS_STALL;
            state_d    = IDLE;
            tx_valid_d = 1'b0;
        end else if (hit) begin
            unique case (state_q)
                IDLE, ADDR: begin
                    hs_valid_d = 1'b1;
                    hs_code_d  = HS_NAK;
                    if (!bus.req_in && is_addr) begin
                        if (bus.req_crc_ok) begin
                            mem_addr_d = bus.req_data[15:0];
                            hs_code_d  = HS_ACK;
                            state_d    = ADDR;
                        end else begin
                            crc_nak = 1'b1;
                        end
                    end else if ((state_q == ADDR) && is_data) begin
                        if (bus.req_in) begin
                            mem_req_d = 1'b1;
                            mem_we_d  = 1'b0;
                            state_d   = MRD;
                        end else if (bus.req_crc_ok) begin
                            hs_valid_d  = 1'b0;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = bus.req_data;
                            state_d     = MWR;
                        end else begin
                            crc_nak = 1'b1;
                        end
                    end
                end
                TXD: begin
                    // A repeated IN just resends the held tx_data; OUT breaks the read.
                    if (!bus.req_in) begin
                        hs_valid_d = 1'b1;
                        hs_code_d  = HS_STALL;
                        state_d    = IDLE;
                        tx_valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end else if ((state_q == TXD) && bus.tx_ack) begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
            rd_done    = 1'b1;
        end else if (tmr_tc) begin
            timeout_d  = 1'b1;
            tx_valid_d = 1'b0;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q      <= IDLE;
            hs_valid_q   <= 1'b0;
            hs_code_q    <= HS_ACK;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 16'd0;
            mem_wdata_q  <= 64'd0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 64'd0;
            timeout_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs_valid_q   <= hs_valid_d;
            hs_code_q    <= hs_code_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            timeout_q    <= timeout_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    assign bus.hs_valid  = hs_valid_q;
    assign bus.hs_code   = hs_code_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.timeout   = timeout_q;
    assign dbg_state     = state_q;

`ifdef USB_DEV_RW_STATS_EN
    logic [15:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [7:0]  crc_cnt_q, crc_cnt_d;

    always_comb begin
        wr_cnt_d  = wr_cnt_q + {15'd0, wr_done};
        rd_cnt_d  = rd_cnt_q + {15'd0, rd_done};
        crc_cnt_d = (crc_nak && (crc_cnt_q != 8'hFF)) ? crc_cnt_q + 8'd1 : crc_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            wr_cnt_q  <= 16'd0;
            rd_cnt_q  <= 16'd0;
            crc_cnt_q <= 8'd0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            crc_cnt_q <= crc_cnt_d;
        end
    end

    assign wr_count      = wr_cnt_q;
    assign rd_count      = rd_cnt_q;
    assign crc_err_count = crc_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = ^{wr_done, rd_done, crc_nak};
`endif
endmodule

// File: tb/tb_usb_dev_rw_responder.sv
// Directed bench for usb_dev_rw_responder: a vector table for single requests plus write/read/timeout/abort sequences.
module tb_usb_dev_rw_responder;
  import usb_dev_pkg::*;

  logic clk = 1'b0;
  logic rst_L = 1'b0;
  state_t dbg_state;
  int total = 0;
  int bad = 0;

  usb_dev_rw_responder_if bus();

`ifdef USB_DEV_RW_STATS_EN
  logic [15:0] wr_count, rd_count;
  logic [7:0]  crc_err_count;
`endif

  usb_dev_rw_responder #(.TIMEOUT(16'd16)) dut (
    .clk       (clk),
    .rst_L     (rst_L),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef USB_DEV_RW_STATS_EN
    ,
    .wr_count      (wr_count),
    .rd_count      (rd_count),
    .crc_err_count (crc_err_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        in_;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    logic        crc;
    logic        exp_hs;
    logic [1:0]  exp_code;
    state_t      exp_state;
    logic [15:0] exp_maddr;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one-cycle decoded request, outputs sampled #1 after the capturing edge
  task automatic send(input logic in_, input logic [6:0] a, input logic [3:0] e,
                      input logic [63:0] d, input logic ok);
    bus.req_valid  = 1'b1;
    bus.req_in     = in_;
    bus.req_addr   = a;
    bus.req_endp   = e;
    bus.req_data   = d;
    bus.req_crc_ok = ok;
    tick();
    bus.req_valid  = 1'b0;
  endtask

  task automatic mem_reply(input logic [63:0] rdata);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdata;
    tick();
    bus.mem_ack   = 1'b0;
  endtask

  task automatic add_vec(input logic v, input logic in_, input logic [6:0] a, input logic [3:0] e,
                         input logic [63:0] d, input logic ok, input logic hs,
                         input logic [1:0] code, input state_t st, input logic [15:0] ma);
    vec_t t;
    t.v = v; t.in_ = in_; t.addr = a; t.endp = e; t.data = d; t.crc = ok;
    t.exp_hs = hs; t.exp_code = code; t.exp_state = st; t.exp_maddr = ma;
    vq.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.req_valid = 1'b0; bus.req_in = 1'b0; bus.req_addr = 7'd0; bus.req_endp = 4'd0;
    bus.req_data = 64'd0; bus.req_crc_ok = 1'b0; bus.abort = 1'b0; bus.tx_ack = 1'b0;
    bus.mem_rdata = 64'd0; bus.mem_ack = 1'b0;

    //                v     in    addr   endp   data           crc   hs    code      state exp maddr
    add_vec(1'b1, 1'b0, 7'd3,    4'd4, 64'h0999, 1'b1, 1'b0, HS_ACK,   IDLE, 16'h0000);
    add_vec(1'b1, 1'b1, 7'd3,    4'd8, 64'h0,    1'b1, 1'b0, HS_ACK,   IDLE, 16'h0000);
    add_vec(1'b1, 1'b0, DEV_ADDR, 4'd4, 64'h0055, 1'b0, 1'b1, HS_NAK,   IDLE, 16'h0000);
    add_vec(1'b1, 1'b1, DEV_ADDR, 4'd8, 64'h0,    1'b1, 1'b1, HS_NAK,   IDLE, 16'h0000);
    add_vec(1'b1, 1'b0, DEV_ADDR, 4'd8, 64'h1234, 1'b1, 1'b1, HS_NAK,   IDLE, 16'h0000);
    add_vec(1'b1, 1'b0, DEV_ADDR, 4'd4, 64'h0123, 1'b1, 1'b1, HS_ACK,   ADDR, 16'h0123);
    add_vec(1'b1, 1'b0, 7'd3,    4'd2, 64'h0,    1'b1, 1'b0, HS_ACK,   ADDR, 16'h0123);
    add_vec(1'b0, 1'b0, DEV_ADDR, 4'd4, 64'h0,    1'b1, 1'b0, HS_ACK,   ADDR, 16'h0123);
    add_vec(1'b1, 1'b0, DEV_ADDR, 4'd4, 64'hFFFF_0456, 1'b1, 1'b1, HS_ACK, ADDR, 16'h0456);
    add_vec(1'b1, 1'b0, DEV_ADDR, 4'd2, 64'h0,    1'b1, 1'b1, HS_STALL, IDLE, 16'h0456);
    add_vec(1'b1, 1'b0, DEV_ADDR, 4'd4, 64'h0077, 1'b0, 1'b1, HS_NAK,   IDLE, 16'h0456);

    // reset state
    tick(); tick();
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_hs_valid", 64'(bus.hs_valid), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("rst_tx_data", bus.tx_data, 64'd0);
    chk("rst_timeout", 64'(bus.timeout), 64'd0);
    rst_L = 1'b1;
    tick();

    // table-driven single requests
    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].v) send(vq[i].in_, vq[i].addr, vq[i].endp, vq[i].data, vq[i].crc);
      else tick();
      chk($sformatf("vec%0d_hs_valid", i), 64'(bus.hs_valid), 64'(vq[i].exp_hs));
      if (vq[i].exp_hs) chk($sformatf("vec%0d_hs_code", i), 64'(bus.hs_code), 64'(vq[i].exp_code));
      chk($sformatf("vec%0d_state", i), 64'(dbg_state), 64'(vq[i].exp_state));
      chk($sformatf("vec%0d_mem_addr", i), 64'(bus.mem_addr), 64'(vq[i].exp_maddr));
    end

    // write: address phase, data phase, memory completion, ACK one cycle after mem_ack
    send(1'b0, DEV_ADDR, 4'd4, 64'h0123, 1'b1);
    chk("wr_addr_ack", 64'({bus.hs_valid, bus.hs_code}), 64'({1'b1, HS_ACK}));
    send(1'b0, DEV_ADDR, 4'd8, 64'hDEADBEEF_CAFEF00D, 1'b1);
    chk("wr_no_hs", 64'(bus.hs_valid), 64'd0);
    chk("wr_state", 64'(dbg_state), 64'(MWR));
    chk("wr_mem_req", 64'({bus.mem_req, bus.mem_we}), 64'b11);
    chk("wr_mem_addr", 64'(bus.mem_addr), 64'h0123);
    chk("wr_mem_wdata", bus.mem_wdata, 64'hDEADBEEF_CAFEF00D);
    tick();
    chk("wr_req_held", 64'(bus.mem_req), 64'd1);
    mem_reply(64'd0);
    chk("wr_ack", 64'({bus.hs_valid, bus.hs_code}), 64'({1'b1, HS_ACK}));
    chk("wr_req_drop", 64'(bus.mem_req), 64'd0);
    chk("wr_idle", 64'(dbg_state), 64'(IDLE));
    tick();
    chk("wr_ack_pulse", 64'(bus.hs_valid), 64'd0);

    // read with retry: NAK, 5-cycle memory, repeated IN sees identical data
    send(1'b0, DEV_ADDR, 4'd4, 64'h0040, 1'b1);
    send(1'b1, DEV_ADDR, 4'd8, 64'd0, 1'b1);
    chk("rd_nak", 64'({bus.hs_valid, bus.hs_code}), 64'({1'b1, HS_NAK}));
    chk("rd_mem", 64'({bus.mem_req, bus.mem_we, bus.mem_addr}), 64'({1'b1, 1'b0, 16'h0040}));
    send(1'b1, DEV_ADDR, 4'd8, 64'd0, 1'b1);
    chk("rd_retry_nak", 64'({bus.hs_valid, bus.hs_code}), 64'({1'b1, HS_NAK}));
    chk("rd_state_mrd", 64'(dbg_state), 64'(MRD));
    tick(); tick(); tick();
    mem_reply(64'h1122334455667788);
    chk("rd_txd", 64'(dbg_state), 64'(TXD));
    chk("rd_mem_req_drop", 64'(bus.mem_req), 64'd0);
    for (int k = 0; k < 2; k++) begin
      send(1'b1, DEV_ADDR, 4'd8, 64'd0, 1'b1);
      chk($sformatf("rd_in%0d_tx_valid", k), 64'(bus.tx_valid), 64'd1);
      chk($sformatf("rd_in%0d_tx_data", k), bus.tx_data, 64'h1122334455667788);
      chk($sformatf("rd_in%0d_no_hs", k), 64'(bus.hs_valid), 64'd0);
    end
    bus.tx_ack = 1'b1; tick(); bus.tx_ack = 1'b0;
    chk("rd_done_state", 64'(dbg_state), 64'(IDLE));
    chk("rd_done_tx_valid", 64'(bus.tx_valid), 64'd0);

    // timeout in ADDR: pulse 16 cycles after the address ACK, then IN is just NAKed
    send(1'b0, DEV_ADDR, 4'd4, 64'h0300, 1'b1);
    chk("to_addr_ack", 64'(bus.hs_valid), 64'd1);
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus.timeout) begin n = c; break; end
    end
    chk("to_cycles", 64'(n), 64'd16);
    chk("to_state", 64'(dbg_state), 64'(IDLE));
    tick();
    chk("to_pulse", 64'(bus.timeout), 64'd0);
    send(1'b1, DEV_ADDR, 4'd8, 64'd0, 1'b1);
    chk("to_in_nak", 64'({bus.hs_valid, bus.hs_code}), 64'({1'b1, HS_NAK}));
    chk("to_in_no_mem", 64'(bus.mem_req), 64'd0);

    // tx_ack on the terminal-count cycle wins over timeout
    send(1'b0, DEV_ADDR, 4'd4, 64'h0041, 1'b1);
    send(1'b1, DEV_ADDR, 4'd8, 64'd0, 1'b1);
    mem_reply(64'hA5A5_0000_5A5A_FFFF);
    chk("tc_txd", 64'(dbg_state), 64'(TXD));
    for (int c = 0; c < 15; c++) tick();
    chk("tc_still_txd", 64'(dbg_state), 64'(TXD));
    bus.tx_ack = 1'b1; tick(); bus.tx_ack = 1'b0;
    chk("tc_no_timeout", 64'(bus.timeout), 64'd0);
    chk("tc_idle", 64'(dbg_state), 64'(IDLE));
    tick();
    chk("tc_no_timeout_late", 64'(bus.timeout), 64'd0);

    // abort during MWR: write completes, no ACK
    send(1'b0, DEV_ADDR, 4'd4, 64'h0200, 1'b1);
    send(1'b0, DEV_ADDR, 4'd8, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    chk("ab_still_mwr", 64'(dbg_state), 64'(MWR));
    chk("ab_mem_req", 64'({bus.mem_req, bus.mem_we}), 64'b11);
    mem_reply(64'd0);
    chk("ab_no_ack", 64'(bus.hs_valid), 64'd0);
    chk("ab_req_drop", 64'(bus.mem_req), 64'd0);
    chk("ab_idle", 64'(dbg_state), 64'(IDLE));

    // abort in ADDR, and abort colliding with a request
    send(1'b0, DEV_ADDR, 4'd4, 64'h0210, 1'b1);
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    chk("ab_addr_idle", 64'({dbg_state, bus.hs_valid}), 64'({IDLE, 1'b0}));
    bus.abort = 1'b1;
    send(1'b0, DEV_ADDR, 4'd4, 64'h0220, 1'b1);
    bus.abort = 1'b0;
    chk("ab_req_dropped", 64'({dbg_state, bus.hs_valid}), 64'({IDLE, 1'b0}));

`ifdef USB_DEV_RW_STATS_EN
    chk("stat_wr", 64'(wr_count), 64'd1);
    chk("stat_rd", 64'(rd_count), 64'd2);
    chk("stat_crc", 64'(crc_err_count), 64'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
